// File: rtl/mac_sched.sv
// mac_sched: round-robin I/Q scheduler that sequences the shared MAC through NTAPS taps per sample.
module mac_sched #(
  parameter int NTAPS = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    req,
  output logic [AW-1:0] tap_addr,
  output logic          mac_ch,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [1:0]    done,
  output logic          busy,
  output logic [1:0]    overrun
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  state_e        state_q, state_d;
  logic [AW-1:0] tap_q, tap_d;
  logic          ch_q, ch_d, last_q, last_d, gnt, gnt_ch;
  logic [1:0]    pend_q, pend_d, ovr_q, ovr_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end
  // a fresh request on the granting edge re-arms pend (set beats clear)
  always_comb begin
    gnt     = en && state_q == IDLE && |pend_q;
    gnt_ch  = &pend_q ? ~last_q : pend_q[1];
    pend_d  = en ? req | (pend_q & ~(gnt ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00)) : pend_q;
    ovr_d   = ovr_q | (en ? req & pend_q : 2'b00);
    state_d = state_q;
    tap_d   = tap_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (en)
      case (state_q)
        IDLE: if (gnt) begin
          state_d = RUN;
          tap_d   = '0;
          ch_d    = gnt_ch;
          last_d  = gnt_ch;
        end
        RUN: begin
          state_d = tap_q == LAST_TAP ? FLUSH : RUN;
          tap_d   = tap_q == LAST_TAP ? '0 : tap_q + AW'(1);
        end
        default: state_d = IDLE;
      endcase
  end
  assign tap_addr = tap_q;
  assign mac_ch   = ch_q;
  assign busy     = state_q != IDLE;
  assign mac_en   = state_q == RUN && en;
  assign mac_clr  = state_q == RUN && tap_q == '0 && en;
  assign done     = state_q == FLUSH && en ? (ch_q ? 2'b10 : 2'b01) : 2'b00;
  assign overrun  = ovr_q;
endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: randomized and directed checks of mac_sched against an occupancy-phase reference model.
module tb_mac_sched;
  localparam int NTAPS = 4;
  localparam int AW    = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] tap_addr;
  logic          mac_ch, mac_clr, mac_en, busy;
  logic [1:0]    done, overrun;
  int total = 0;
  int bad = 0;
  // model: m_ph is the position inside a sample's NTAPS+2 cycle occupancy, -1 when free
  int            m_ph;
  logic          m_ch, m_last;
  logic [1:0]    m_pend, m_ovr;
  logic [AW+7:0] obs, exp_v;
  logic [1:0]    o_done, o_ovr;
  logic          o_en, o_busy;
  logic [AW-1:0] o_tap;

  always #5 clk = ~clk;

  mac_sched #(.NTAPS(NTAPS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .tap_addr(tap_addr),
    .mac_ch(mac_ch), .mac_clr(mac_clr), .mac_en(mac_en), .done(done),
    .busy(busy), .overrun(overrun)
  );

  task automatic m_reset();
    m_ph = -1; m_ch = 1'b0; m_last = 1'b1; m_pend = 2'b00; m_ovr = 2'b00;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; en = 1'b1; req = 2'b00;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic cyc(input logic e, input logic [1:0] r);
    logic run, fl, free, g;
    logic [1:0] d;
    @(negedge clk);
    en = e; req = r;
    #1;
    run = m_ph >= 0 && m_ph < NTAPS;
    fl  = m_ph == NTAPS;
    d   = (fl && e) ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
    exp_v = {run || fl, m_ch, run && e, run && m_ph == 0 && e, d, m_ovr, run ? AW'(m_ph) : AW'(0)};
    obs   = {busy, mac_ch, mac_en, mac_clr, done, overrun, tap_addr};
    o_done = done; o_en = mac_en; o_tap = tap_addr; o_busy = busy; o_ovr = overrun;
    @(posedge clk);
    if (e) begin
      free  = m_ph < 0 || m_ph == NTAPS + 1;
      m_ovr = m_ovr | (r & m_pend);
      if (free && m_pend != 2'b00) begin
        g = (m_pend == 2'b11) ? !m_last : m_pend[1];
        m_pend[g] = 1'b0;
        m_ch = g; m_last = g; m_ph = 0;
      end else m_ph = free ? -1 : m_ph + 1;
      m_pend = m_pend | r;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'b00);
      total++;
      if (obs !== exp_v || {o_tap, o_en, o_done, o_busy, o_ovr} !== '0) begin
        bad++; $display("FAIL reset c=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_single();
    int dc = -1, ne = 0;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i == 0 ? 2'b01 : 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single c=%0d got=%h exp=%h", i, obs, exp_v); end
      if (o_done == 2'b01 && dc < 0) dc = i;
      ne += int'(o_en);
    end
    total++;
    if (dc != 6 || ne != 4) begin bad++; $display("FAIL single_timing done_cyc=%0d mac_en_cnt=%0d exp 6/4", dc, ne); end
  endtask

  task automatic test_simul();
    int d0 = -1, d1 = -1;
    logic [1:0] nxt = 2'b01;
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, i == 0 ? 2'b11 : 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL simul c=%0d got=%h exp=%h", i, obs, exp_v); end
      if (o_done == 2'b01) d0 = i;
      if (o_done == 2'b10) d1 = i;
    end
    total++;
    if (d0 != 6 || d1 != 12) begin bad++; $display("FAIL simul_timing d0=%0d d1=%0d exp 6/12", d0, d1); end
    for (int rnd = 0; rnd < 3; rnd++)
      for (int i = 0; i < 14; i++) begin
        cyc(1'b1, i == 0 ? 2'b11 : 2'b00);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL alt c=%0d got=%h exp=%h", i, obs, exp_v); end
        if (o_done != 2'b00) begin
          total++;
          if (o_done !== nxt) begin bad++; $display("FAIL alt_order rnd=%0d got=%b exp=%b", rnd, o_done, nxt); end
          nxt = ~nxt;
        end
      end
  endtask

  task automatic test_gated();
    int ne = 0, nd = 0, dc = -1;
    logic e;
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      e = (i % 4) == 0;
      cyc(e, i == 0 ? 2'b10 : (e ? 2'b00 : 2'($urandom_range(0, 3))));
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL gated c=%0d got=%h exp=%h", i, obs, exp_v); end
      ne += int'(o_en);
      if (o_done != 2'b00) begin nd++; dc = i; end
    end
    total++;
    if (ne != 4 || nd != 1 || dc != 24) begin
      bad++; $display("FAIL gated_counts mac_en=%0d done=%0d at=%0d exp 4/1/24", ne, nd, dc);
    end
  endtask

  task automatic test_overrun();
    int nd1 = 0, dc = -1;
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i == 0 ? 2'b01 : (i == 1 || i == 3) ? 2'b10 : 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL overrun c=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i >= 4) begin
        total++;
        if (o_ovr !== 2'b10) begin bad++; $display("FAIL overrun_flag c=%0d got=%b exp=10", i, o_ovr); end
      end
      if (o_done == 2'b10) begin nd1++; dc = i; end
    end
    total++;
    if (nd1 != 1 || dc != 12) begin bad++; $display("FAIL overrun_service cnt=%0d at=%0d exp 1/12", nd1, dc); end
  endtask

  task automatic test_reset_mid();
    int hit = 0, first = -1;
    logic [1:0] fd = 2'b00;
    do_reset(2);
    cyc(1'b1, 2'b01);
    for (int i = 0; i < 10 && hit == 0; i++) begin
      cyc(1'b1, 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_pre c=%0d got=%h exp=%h", i, obs, exp_v); end
      if (o_en && o_tap == AW'(1)) hit = 1;
    end
    total++;
    if (hit == 0) begin bad++; $display("FAIL mid_timeout tap never reached got=0 exp=1"); end
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0 ? 2'b11 : 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_post c=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 0) begin
        total++;
        if ({o_busy, o_en, o_done, o_ovr} !== '0) begin
          bad++; $display("FAIL mid_idle got=%b exp=0", {o_busy, o_en, o_done, o_ovr});
        end
      end
      if (o_done != 2'b00 && first < 0) begin first = i; fd = o_done; end
    end
    total++;
    if (fd !== 2'b01 || first != 6) begin bad++; $display("FAIL mid_first got=%b@%0d exp=01@6", fd, first); end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_simul();
    test_gated();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
